// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide unit, 32-cycle shift-add multiply and radix-2 restoring divide.
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle from a combinational product.

`ifndef W_DATA
`define W_DATA 32
`endif
`ifndef W_FUNC
`define W_FUNC 2
`endif
`ifndef FUNC_MUL
`define FUNC_MUL 2'd1
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 2'd2
`endif
`ifndef OPER_ALUS
`define OPER_ALUS 1'b1
`endif
`ifndef OPER_ALUU
`define OPER_ALUU 1'b0
`endif

module muldiv_ctrl (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [`W_FUNC-1:0] func,
    input  logic               sgn,
    input  logic [`W_DATA-1:0] opa,
    input  logic [`W_DATA-1:0] opb,
    input  logic               mthi,
    input  logic               mtlo,
    input  logic [`W_DATA-1:0] wdata,
    input  logic               flush,
    output logic [`W_DATA-1:0] hi,
    output logic [`W_DATA-1:0] lo,
    output logic               busy,
    output logic               done
);
    localparam int DATA_W = `W_DATA;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t                state_q, state_d;
    logic [4:0]            cnt_q;
    logic                  div_q;
    logic                  neg_res_q;
    logic                  neg_rem_q;
    logic                  dz_q;
    logic [DATA_W-1:0]     opa_q;
    logic [DATA_W-1:0]     mag_b_q;
    logic [2*DATA_W-1:0]   acc_q;

    logic                  is_sgn, legal, accept;
    logic [DATA_W:0]       mul_sum;
    logic [2*DATA_W-1:0]   mul_next, mul_res;
    logic [DATA_W:0]       div_shift;
    logic                  div_ge;
    logic [DATA_W-1:0]     div_rem;
    logic [2*DATA_W-1:0]   div_next;
    logic [DATA_W-1:0]     fix_hi, fix_lo;

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic s);
        return neg_if(v, s & v[DATA_W-1]);
    endfunction

    function automatic logic [2*DATA_W-1:0] neg64_if(input logic [2*DATA_W-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign is_sgn = (sgn == `OPER_ALUS);
    assign legal  = (func == `FUNC_MUL) || (func == `FUNC_DIV);
    assign accept = req && !flush && (state_q == IDLE) && legal;
    assign busy   = (state_q != IDLE);

`ifdef MULDIV_FAST_MUL_EN
    logic                  fast_mul;
    logic [2*DATA_W-1:0]   fast_a, fast_b, fast_prod;

    // Sign-extended operands; the low 64 bits of the product are correct for both signednesses
    assign fast_a    = {{DATA_W{is_sgn & opa[DATA_W-1]}}, opa};
    assign fast_b    = {{DATA_W{is_sgn & opb[DATA_W-1]}}, opb};
    assign fast_prod = fast_a * fast_b;
    assign fast_mul  = accept && (func == `FUNC_MUL);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
                    if (func == `FUNC_DIV) state_d = DIV;
`else
                    state_d = (func == `FUNC_DIV) ? DIV : MUL;
`endif
                end
            end
            MUL, DIV: begin
                if (flush) state_d = IDLE;
                else if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Multiply step: acc = {partial product, remaining multiplier bits}, shifted right each cycle
    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

    // Divide step: acc = {remainder, dividend/quotient}, one quotient bit shifted in per cycle
    assign div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    assign div_ge    = (div_shift >= {1'b0, mag_b_q});
    assign div_rem   = div_ge ? DATA_W'(div_shift - {1'b0, mag_b_q}) : div_shift[DATA_W-1:0];
    assign div_next  = {div_rem, acc_q[DATA_W-2:0], div_ge};

    assign mul_res = neg64_if(acc_q, neg_res_q);
    assign fix_lo  = div_q ? (dz_q ? '1 : neg_if(acc_q[DATA_W-1:0], neg_res_q))
                           : mul_res[DATA_W-1:0];
    assign fix_hi  = div_q ? (dz_q ? opa_q : neg_if(acc_q[2*DATA_W-1:DATA_W], neg_rem_q))
                           : mul_res[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) cnt_q <= '0;
            else if (state_q == MUL || state_q == DIV) cnt_q <= cnt_q + 5'd1;

            if (state_q == FIX && !flush) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (fast_mul) begin
                hi <= fast_prod[2*DATA_W-1:DATA_W];
                lo <= fast_prod[DATA_W-1:0];
            end
`endif
            else if (state_q == IDLE && !accept) begin
                if (mthi) hi <= wdata;
                if (mtlo) lo <= wdata;
            end

`ifdef MULDIV_FAST_MUL_EN
            done <= (state_q == FIX && !flush) || fast_mul;
`else
            done <= (state_q == FIX && !flush);
`endif
        end
    end

    // Operand capture and iteration datapath; reset only matters for control
    always_ff @(posedge clk) begin
        if (accept) begin
            div_q     <= (func == `FUNC_DIV);
            opa_q     <= opa;
            mag_b_q   <= mag(opb, is_sgn);
            acc_q     <= {{DATA_W{1'b0}}, mag(opa, is_sgn)};
            neg_res_q <= is_sgn & (opa[DATA_W-1] ^ opb[DATA_W-1]);
            neg_rem_q <= is_sgn & opa[DATA_W-1];
            dz_q      <= (opb == '0);
        end else if (state_q == MUL) begin
            acc_q <= mul_next;
        end else if (state_q == DIV) begin
            acc_q <= div_next;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench for muldiv_ctrl; expected HI/LO/latency queued at issue, popped at done.

`ifndef W_DATA
`define W_DATA 32
`endif
`ifndef W_FUNC
`define W_FUNC 2
`endif
`ifndef FUNC_MUL
`define FUNC_MUL 2'd1
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 2'd2
`endif

module tb_muldiv_ctrl;
    logic               clk = 1'b0;
    logic               rst, req, sgn, mthi, mtlo, flush;
    logic [`W_FUNC-1:0] func;
    logic [31:0]        opa, opb, wdata;
    logic [31:0]        hi, lo;
    logic               busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .func(func), .sgn(sgn),
        .opa(opa), .opb(opb), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: {HI, LO}
    function automatic logic [63:0] model(input logic [`W_FUNC-1:0] f, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        xa, xb;
        logic signed [31:0] sa, sb;
        logic [31:0]        q, r;
        if (f == `FUNC_MUL) begin
            xa = s ? {{32{a[31]}}, a} : {32'b0, a};
            xb = s ? {{32{b[31]}}, b} : {32'b0, b};
            return xa * xb;
        end
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (s) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic issue(input string name, input logic [`W_FUNC-1:0] f, input logic s,
                         input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        exp_t e;
        e.hi   = exp[63:32];
        e.lo   = exp[31:0];
        e.name = name;
        e.lat  = 34;
`ifdef MULDIV_FAST_MUL_EN
        if (f == `FUNC_MUL) e.lat = 1;
`endif
        exp_q.push_back(e);
        req  = 1'b1;
        func = f;
        sgn  = s;
        opa  = a;
        opb  = b;
        step();
        req = 1'b0;
        opa = $urandom;
        opb = $urandom;
    endtask

    // Waits for done (bounded), pops the scoreboard and compares latency and HI/LO
    task automatic wait_done(input int start_lat);
        int   lat;
        exp_t e;
        lat = start_lat;
        while (done !== 1'b1 && lat < 60) begin
            step();
            lat++;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: done=%b with nothing expected", done);
            return;
        end
        e = exp_q.pop_front();
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles, required at cycle %0d", e.name, lat, e.lat);
            return;
        end
        if (lat != e.lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, expected %0d", e.name, lat, e.lat);
        end
        checks++;
        if (hi !== e.hi) begin
            errors++;
            $display("FAIL %s_hi: got %h, expected %h", e.name, hi, e.hi);
        end
        checks++;
        if (lo !== e.lo) begin
            errors++;
            $display("FAIL %s_lo: got %h, expected %h", e.name, lo, e.lo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b1; func = `FUNC_DIV; mthi = 1'b1; mtlo = 1'b1;
        wdata = 32'hDEAD; flush = 1'b1; sgn = 1'b0; opa = 32'd9; opb = 32'd3;
        step();
        step();
        checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL reset_hi: got %h, expected 0", hi); end
        checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL reset_lo: got %h, expected 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
        req = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0; rst = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_div();
        issue("div_u_100_7", `FUNC_DIV, 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div_busy: got %b, expected 1", busy); end
        wait_done(1);
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL div_done_width: got %b, expected 0", done); end
        issue("div_s_m7_2", `FUNC_DIV, 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
        wait_done(1);
        step();
    endtask

    task automatic test_mul();
        issue("mul_s", `FUNC_MUL, 1'b1, 32'hFFFFFFFF, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFE});
`ifdef MULDIV_FAST_MUL_EN
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy: got %b, expected 0", busy); end
`else
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy: got %b, expected 1", busy); end
`endif
        wait_done(1);
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_width: got %b, expected 0", done); end
        issue("mul_u", `FUNC_MUL, 1'b0, 32'hFFFFFFFF, 32'd2, {32'h1, 32'hFFFFFFFE});
        wait_done(1);
        step();
    endtask

    task automatic test_div_special();
        issue("div0_s", `FUNC_DIV, 1'b1, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF});
        wait_done(1);
        step();
        issue("div0_u_neg", `FUNC_DIV, 1'b0, 32'hFFFFFFF0, 32'd0, {32'hFFFFFFF0, 32'hFFFFFFFF});
        wait_done(1);
        step();
        issue("div_ovf", `FUNC_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
        wait_done(1);
        step();
    endtask

    task automatic test_random();
        logic [`W_FUNC-1:0] f;
        logic               s;
        logic [31:0]        a, b;
        for (int i = 0; i < 8; i++) begin
            f = ($urandom_range(0, 1) == 0) ? `FUNC_MUL : `FUNC_DIV;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 100);
                2:       b = -$urandom_range(1, 100);
                default: b = $urandom;
            endcase
            issue("rand", f, s, a, b, model(f, s, a, b));
            wait_done(1);
            step();
        end
    endtask

    task automatic test_illegal();
        int seen;
        seen = 0;
        for (int f = 0; f < 4; f += 3) begin
            req = 1'b1; func = `W_FUNC'(f); sgn = 1'b0; opa = 32'd8; opb = 32'd2;
            step();
            req = 1'b0;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_func_busy: func=%0d busy=%b, expected 0", f, busy); end
            if (done === 1'b1) seen++;
        end
        for (int k = 0; k < 2; k++) begin
            req = 1'b1; flush = 1'b1; func = (k == 0) ? `FUNC_DIV : `FUNC_MUL;
            step();
            req = 1'b0; flush = 1'b0;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL req_with_flush_busy: got %b, expected 0", busy); end
            if (done === 1'b1) seen++;
        end
        repeat (3) begin
            step();
            if (done === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL illegal_done: %0d done pulses, expected 0", seen); end
    endtask

    task automatic test_flush();
        int seen;
        seen = 0;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0F0F1234;
        step();
        mthi = 1'b0; mtlo = 1'b0;
        req = 1'b1; func = `FUNC_DIV; sgn = 1'b0; opa = 32'd1000; opb = 32'd3;
        step();
        req = 1'b0;
        repeat (9) step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %b, expected 1", busy); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b, expected 0", busy); end
        repeat (40) begin
            if (done === 1'b1) seen++;
            step();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_done: %0d done pulses, expected 0", seen); end
        checks++; if (hi !== 32'h0F0F1234) begin errors++; $display("FAIL flush_hi: got %h, expected 0f0f1234", hi); end
        checks++; if (lo !== 32'h0F0F1234) begin errors++; $display("FAIL flush_lo: got %h, expected 0f0f1234", lo); end
    endtask

    task automatic test_mt_stall();
        int          n, bad;
        logic [31:0] bad_val;
        bad = 0;
        bad_val = '0;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAAAA;
        step();
        mthi = 1'b0;
        wdata = 32'h5555;
        issue("div_mt", `FUNC_DIV, 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        mtlo = 1'b0;
        checks++; if (lo !== 32'hAAAA) begin errors++; $display("FAIL mt_req_priority_lo: got %h, expected 0000aaaa", lo); end
        mthi = 1'b1; wdata = 32'h1234;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            if (hi !== 32'hAAAA) begin bad++; bad_val = hi; end
            req = (n < 5); func = `FUNC_MUL; opa = 32'd3; opb = 32'd3;
            step();
            n++;
        end
        req = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL mt_stall_hi: got %h while busy, expected 0000aaaa", bad_val); end
        wait_done(1 + n);
        step();
        mthi = 1'b0;
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mt_after_idle_hi: got %h, expected 00001234", hi); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mt_extra_done: got %b, expected 0", done); end
    endtask

    task automatic test_back_to_back();
        issue("b2b_div", `FUNC_DIV, 1'b1, 32'd12345, 32'hFFFFFFF6, model(`FUNC_DIV, 1'b1, 32'd12345, 32'hFFFFFFF6));
        wait_done(1);
        issue("b2b_mul", `FUNC_MUL, 1'b1, 32'h7FFFFFFF, 32'h80000000, model(`FUNC_MUL, 1'b1, 32'h7FFFFFFF, 32'h80000000));
        wait_done(1);
        issue("b2b_div2", `FUNC_DIV, 1'b0, 32'hFFFFFFFF, 32'd16, {32'd15, 32'h0FFFFFFF});
        wait_done(1);
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_width: got %b, expected 0", done); end
    endtask

    task automatic test_rst_mid_div();
        int seen_done, seen_busy;
        seen_done = 0;
        seen_busy = 0;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h77;
        step();
        mthi = 1'b0; mtlo = 1'b0;
        req = 1'b1; func = `FUNC_DIV; sgn = 1'b1; opa = 32'd500; opb = 32'd9;
        step();
        req = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL rst_mid_hi: got %h, expected 0", hi); end
        checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL rst_mid_lo: got %h, expected 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b, expected 0", busy); end
        repeat (40) begin
            if (done === 1'b1) seen_done++;
            if (busy === 1'b1) seen_busy++;
            step();
        end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL rst_mid_done: %0d done pulses, expected 0", seen_done); end
        checks++; if (seen_busy != 0) begin errors++; $display("FAIL rst_mid_busy_later: busy high %0d cycles, expected 0", seen_busy); end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; func = '0; sgn = 1'b0; opa = '0; opb = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0; flush = 1'b0;
        test_reset();
        test_div();
        test_mul();
        test_div_special();
        test_random();
        test_illegal();
        test_flush();
        test_mt_stall();
        test_back_to_back();
        test_rst_mid_div();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d expected results never produced", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
